// File: rtl/hpdcache_pkg.sv
// Shared HPDcache request types and CMO sub-operation encodings.
// The CMO sub-operation travels in the request size field (3 bits).
package hpdcache_pkg;

  typedef logic [1:0] hpdcache_req_sid_t;
  typedef logic [5:0] hpdcache_req_tid_t;

  typedef logic [2:0] hpdcache_req_cmo_t;

  localparam hpdcache_req_cmo_t HPDCACHE_REQ_CMO_PREFETCH    = 3'h1;
  localparam hpdcache_req_cmo_t HPDCACHE_REQ_CMO_INVAL_NLINE = 3'h2;
  localparam hpdcache_req_cmo_t HPDCACHE_REQ_CMO_INVAL_ALL   = 3'h4;

endpackage

// File: rtl/hpdcache_cmo_handler.sv
// CMO request handler: decodes the sub-operation of one cache-maintenance
// request at a time and drives directory lookup/invalidate and prefetch.
// Optional feature macro: HPDCACHE_CMO_PREFETCH_EN (when undefined, PREFETCH
// is treated as a no-op and the prefetch port is tied off).
//
// Handshakes: every valid/strobe output (dir_check_o, dir_inval_o, pf_valid_o)
// is held with stable payload until its ready (dir_ready_i / pf_ready_i) is
// seen high on a rising edge; a transfer happens on exactly that edge.
// req_ready_o is high only in IDLE, so one request is in flight at a time.
module hpdcache_cmo_handler
  import hpdcache_pkg::*;
#(
  parameter int unsigned NSETS   = 64,
  parameter int unsigned NWAYS   = 4,
  parameter int unsigned NLINE_W = 26,
  parameter int unsigned SET_W   = $clog2(NSETS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_cmo_i,
  input  logic [NLINE_W-1:0]   req_nline_i,
  input  hpdcache_req_sid_t    req_sid_i,
  input  hpdcache_req_tid_t    req_tid_i,
  input  logic                 req_need_rsp_i,
  output logic                 dir_check_o,
  output logic [NLINE_W-1:0]   dir_check_nline_o,
  input  logic [NWAYS-1:0]     dir_hit_way_i,
  output logic                 dir_inval_o,
  output logic [SET_W-1:0]     dir_inval_set_o,
  output logic [NWAYS-1:0]     dir_inval_way_o,
  input  logic                 dir_ready_i,
  output logic                 pf_valid_o,
  input  logic                 pf_ready_i,
  output logic [NLINE_W-1:0]   pf_nline_o,
  output logic                 rsp_valid_o,
  output hpdcache_req_sid_t    rsp_sid_o,
  output hpdcache_req_tid_t    rsp_tid_o,
  output logic                 busy_o,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WAIT_HIT = 3'd2,
    ST_INVAL    = 3'd3,
    ST_WALK     = 3'd4,
    ST_PREFETCH = 3'd5,
    ST_RSP      = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [NLINE_W-1:0] nline_q;
  hpdcache_req_sid_t  sid_q;
  hpdcache_req_tid_t  tid_q;
  logic               need_rsp_q;
  logic [NWAYS-1:0]   way_q;
  logic [SET_W-1:0]   cnt_q;

  logic accept;
  logic done;
  logic rsp_req;

  // A no-op finishes in IDLE itself, before need_rsp has been latched.
  assign rsp_req = (state_q == ST_IDLE) ? req_need_rsp_i : need_rsp_q;

`ifndef HPDCACHE_CMO_PREFETCH_EN
  logic unused_pf_ready;
  assign unused_pf_ready = pf_ready_i;
`endif

  // Next-state decode and all handshake outputs, derived from the current state.
  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    done              = 1'b0;
    req_ready_o       = 1'b0;
    dir_check_o       = 1'b0;
    dir_check_nline_o = '0;
    dir_inval_o       = 1'b0;
    dir_inval_set_o   = '0;
    dir_inval_way_o   = '0;
    pf_valid_o        = 1'b0;
    pf_nline_o        = '0;
    rsp_valid_o       = 1'b0;
    rsp_sid_o         = '0;
    rsp_tid_o         = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept = 1'b1;
          if (req_cmo_i == HPDCACHE_REQ_CMO_INVAL_NLINE) begin
            state_d = ST_CHECK;
          end else if (req_cmo_i == HPDCACHE_REQ_CMO_INVAL_ALL) begin
            state_d = ST_WALK;
          end else if (req_cmo_i == HPDCACHE_REQ_CMO_PREFETCH) begin
`ifdef HPDCACHE_CMO_PREFETCH_EN
            state_d = ST_PREFETCH;
`else
            done = 1'b1;
`endif
          end else begin
            // clean/flush codes are accepted and completed without action
            done = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        dir_check_o       = 1'b1;
        dir_check_nline_o = nline_q;
        if (dir_ready_i) state_d = ST_WAIT_HIT;
      end
      ST_WAIT_HIT: begin
        if (|dir_hit_way_i) state_d = ST_INVAL;
        else                done    = 1'b1;
      end
      ST_INVAL: begin
        dir_inval_o     = 1'b1;
        dir_inval_set_o = nline_q[SET_W-1:0];
        dir_inval_way_o = way_q;
        if (dir_ready_i) done = 1'b1;
      end
      ST_WALK: begin
        dir_inval_o     = 1'b1;
        dir_inval_set_o = cnt_q;
        dir_inval_way_o = '1;
        if (dir_ready_i && (cnt_q == SET_W'(NSETS - 1))) done = 1'b1;
      end
      ST_PREFETCH: begin
`ifdef HPDCACHE_CMO_PREFETCH_EN
        pf_valid_o = 1'b1;
        pf_nline_o = nline_q;
        if (pf_ready_i) done = 1'b1;
`else
        done = 1'b1;
`endif
      end
      ST_RSP: begin
        rsp_valid_o = 1'b1;
        rsp_sid_o   = sid_q;
        rsp_tid_o   = tid_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) state_d = rsp_req ? ST_RSP : ST_IDLE;
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Request fields, sampled hit way and set-walk counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nline_q    <= '0;
      sid_q      <= '0;
      tid_q      <= '0;
      need_rsp_q <= 1'b0;
      way_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        nline_q    <= req_nline_i;
        sid_q      <= req_sid_i;
        tid_q      <= req_tid_i;
        need_rsp_q <= req_need_rsp_i;
        if (req_cmo_i == HPDCACHE_REQ_CMO_INVAL_ALL) cnt_q <= '0;
      end
      if (state_q == ST_WAIT_HIT) way_q <= dir_hit_way_i;
      // wraps to 0 after the last set since NSETS is a power of two
      if ((state_q == ST_WALK) && dir_ready_i) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/hpdcache_cmo_handler.md
# hpdcache_cmo_handler

Executes cache-maintenance requests arriving on the HPDcache core request port with op HPDCACHE_REQ_CMO, acting as the responder for the core-side CMO adapter. Decodes the CMO sub-operation carried in the request size field and drives the cache directory and the prefetch path. It walks sets for invalidate-all, looks up and invalidates a single line for invalidate-nline, and forwards prefetches to the miss handler. It optionally returns a completion response when the request asks for one.

## Interface
Parameters:
- NSETS, 64, number of cache sets (power of two, ≥2)
- NWAYS, 4, number of ways
- NLINE_W, 26, cache-line address width
- SET_W, $clog2(NSETS), set index width
- Request sid/tid types come from hpdcache_pkg (hpdcache_req_sid_t, hpdcache_req_tid_t)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  CMO request valid
- req_ready_o  out  1  handler can accept a request
- req_cmo_i  in  3  CMO sub-op, taken from the request size field
- req_nline_i  in  NLINE_W  target line address
- req_sid_i / req_tid_i  in  sid/tid types  requester IDs
- req_need_rsp_i  in  1  completion response required
- dir_check_o  out  1  directory lookup strobe for dir_check_nline_o
- dir_check_nline_o  out  NLINE_W  line to look up
- dir_hit_way_i  in  NWAYS  one-hot hit way, valid the cycle after dir_check_o; all-zero means miss
- dir_inval_o  out  1  invalidate strobe
- dir_inval_set_o  out  SET_W  set to invalidate
- dir_inval_way_o  out  NWAYS  way mask to invalidate
- dir_ready_i  in  1  directory accepts check/inval this cycle
- pf_valid_o / pf_ready_i  out/in  1  prefetch handshake to the miss handler
- pf_nline_o  out  NLINE_W  line to prefetch
- rsp_valid_o  out  1  completion pulse
- rsp_sid_o / rsp_tid_o  out  sid/tid types  IDs of the completed request
- busy_o  out  1  handler not in IDLE

## Operation
- FSM states: IDLE, CHECK, WAIT_HIT, INVAL, WALK, PREFETCH, RSP.
- IDLE: req_ready_o=1. On req_valid_i, latch cmo, nline, sid, tid and need_rsp, then decode:
  - INVAL_NLINE → CHECK
  - INVAL_ALL → WALK with set counter = 0
  - PREFETCH → PREFETCH
  - any other code (clean/flush placeholders) → done, a no-op
- CHECK: assert dir_check_o with the latched nline. On dir_ready_i → WAIT_HIT.
- WAIT_HIT: sample dir_hit_way_i. Non-zero → INVAL with way mask = sampled value. Zero → done.
- INVAL: dir_inval_o=1, set = nline[SET_W-1:0], way mask latched. On dir_ready_i → done.
- WALK: dir_inval_o=1, set = counter, way mask all ones.
  - Each cycle with dir_ready_i, increment the counter.
  - When the counter equals NSETS-1 and dir_ready_i is high → done. The counter wraps to 0.
- PREFETCH: pf_valid_o=1 with the latched nline. On pf_ready_i → done.
- done: if need_rsp → RSP, else → IDLE.
- RSP: rsp_valid_o=1 for one cycle with the latched sid/tid → IDLE.
- Strobes are held stable until accepted. Only one request is in flight; no new request is accepted outside IDLE.

## Timing
- Reset values: all strobes/valids 0, req_ready_o=1, busy_o=0, sid/tid/set outputs 0, way mask 0, counter 0, state IDLE.
- Asserting reset mid-operation aborts the operation immediately. The walk is not resumed and no response is issued.
- Latency from acceptance to IDLE, with ready always high and need_rsp=0:
  - INVAL_NLINE hit: 3 cycles
  - INVAL_NLINE miss: 2 cycles
  - INVAL_ALL: NSETS cycles
  - PREFETCH: 1 cycle
  - no-op: 0 cycles (back in IDLE the next cycle)
- need_rsp=1 adds 1 cycle. rsp_valid_o is asserted in that added cycle.
- Back-to-back requests are accepted on the first IDLE cycle.

## Configuration
- HPDCACHE_CMO_PREFETCH_EN defined: prefetch behaves as described above.
- HPDCACHE_CMO_PREFETCH_EN undefined: PREFETCH is decoded as a no-op. pf_valid_o is tied to 0 and pf_nline_o to 0; pf_ready_i is ignored. The response (if requested) follows the next cycle.

## Structure
- hpdcache_pkg holds:
  - CMO sub-op encodings (HPDCACHE_REQ_CMO_INVAL_NLINE, HPDCACHE_REQ_CMO_INVAL_ALL, HPDCACHE_REQ_CMO_PREFETCH)
  - hpdcache_req_sid_t, hpdcache_req_tid_t
- The FSM state enum is local to the module.
- No sub-module; the set-walk counter is inline.

## Test plan
- INVAL_NLINE, nline=0x40, hit way 4'b0100, ready high → one dir_inval_o with set 0x00 and way mask 4'b0100, 3 cycles after acceptance; no rsp since need_rsp=0.
- INVAL_NLINE miss (hit 4'b0000), need_rsp=1, tid=5 → no dir_inval_o; rsp_valid_o pulse with tid 5 two cycles after acceptance.
- INVAL_ALL, NSETS=64, dir_ready_i low every 4th cycle → exactly 64 accepted invals for sets 0..63 in order, all ways, counter back at 0.
- PREFETCH, nline=0x123, pf_ready_i held low 5 cycles → pf_valid_o held with 0x123 for 6 cycles; req_ready_o=0 throughout.
- Reset asserted in WALK at set 17 → all outputs at reset values immediately; next INVAL_ALL restarts at set 0.
- HPDCACHE_CMO_PREFETCH_EN undefined, PREFETCH with need_rsp=1 → pf_valid_o never high; rsp_valid_o the cycle after acceptance.
